// File: rtl/lcd_driver.sv
// ---------------------------------------------------------------------------
// lcd_driver
//
// Hardware controller for an HD44780-style character LCD. Command and data
// bytes arrive from the CPU through a valid/ready write port. They are
// buffered in a small FIFO and then shifted out one at a time. Each byte
// gets a guaranteed setup time, an enable pulse width, a hold time and an
// execution wait. Clear and home commands get the longer wait.
//
// Optional feature macro: LCD_INIT_EN
//   When defined, the controller waits 8*T_CLEAR cycles after reset. It then
//   issues the power-on command sequence 0x38, 0x0C, 0x06, 0x01 before it
//   serves any queued byte. Writes keep queueing during that time.
//
// Ports:
//   i_clk       single clock
//   i_rst_n     asynchronous active-low reset
//   i_wr_vld    write request
//   i_wr_rs     register select of the written byte (0 command, 1 data)
//   i_wr_data   byte to send
//   o_wr_rdy    FIFO not full (write is accepted when vld && rdy)
//   i_lcd_on    LCD power/backlight request
//   o_busy      FIFO non-empty or a transfer in progress
//   o_lcd_data  LCD data bus
//   o_lcd_rs    LCD register select
//   o_lcd_rw    LCD read/write (tied to write)
//   o_lcd_en    LCD enable strobe
//   o_lcd_on    registered i_lcd_on
//   o_io_lcd    packed pin mirror {on, 20'b0, en, rs, rw, data}
// ---------------------------------------------------------------------------
module lcd_driver #(
  parameter int T_SETUP    = 2,
  parameter int T_PULSE    = 12,
  parameter int T_HOLD     = 2,
  parameter int T_EXEC     = 2000,
  parameter int T_CLEAR    = 82000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_wr_vld,
  input  logic        i_wr_rs,
  input  logic [7:0]  i_wr_data,
  output logic        o_wr_rdy,
  input  logic        i_lcd_on,
  output logic        o_busy,
  output logic [7:0]  o_lcd_data,
  output logic        o_lcd_rs,
  output logic        o_lcd_rw,
  output logic        o_lcd_en,
  output logic        o_lcd_on,
  output logic [31:0] o_io_lcd
);

  localparam int AW = $clog2(FIFO_DEPTH);

  // The counter must hold the largest wait it is ever loaded with.
  localparam int MAX_A = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int MAX_B = (MAX_A > T_HOLD) ? MAX_A : T_HOLD;
  localparam int MAX_C = (MAX_B > T_EXEC) ? MAX_B : T_EXEC;
  localparam int MAX_D = (MAX_C > T_CLEAR) ? MAX_C : T_CLEAR;
`ifdef LCD_INIT_EN
  localparam int MAX_T = ((8 * T_CLEAR) > MAX_D) ? (8 * T_CLEAR) : MAX_D;
`else
  localparam int MAX_T = MAX_D;
`endif
  localparam int CW = $clog2(MAX_T) + 1;

  localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] LD_PULSE = CW'(T_PULSE - 1);
  localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
  localparam logic [CW-1:0] LD_CLEAR = CW'(T_CLEAR - 1);
`ifdef LCD_INIT_EN
  localparam logic [CW-1:0] LD_INIT  = CW'(8 * T_CLEAR - 1);
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC,
    ST_INIT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;

  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_nxt;
  logic          full, empty, push, pop;

  logic          lcd_rs, lcd_rs_nxt;
  logic [7:0]    lcd_data, lcd_data_nxt;
  logic          lcd_en, lcd_on, busy, busy_nxt;
  logic          is_long_cmd;

`ifdef LCD_INIT_EN
  logic [2:0]    init_idx, init_idx_nxt;
  logic          init_pending;
  logic [7:0]    init_cmd;
`endif

  // Fullness comes from the registered count only, so a full FIFO refuses
  // a write even on a cycle where the FSM pops.
  assign full  = (count == (AW + 1)'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign push  = i_wr_vld && !full;

  // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
  assign is_long_cmd = !lcd_rs &&
                       ((lcd_data == 8'h01) || (lcd_data == 8'h02) || (lcd_data == 8'h03));

`ifdef LCD_INIT_EN
  assign init_pending = (init_idx < 3'd4);

  always_comb begin
    case (init_idx)
      3'd0:    init_cmd = 8'h38;
      3'd1:    init_cmd = 8'h0C;
      3'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  end
`endif

  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // FIFO storage has no reset; only the pointers and count define contents.
  always_ff @(posedge i_clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {i_wr_rs, i_wr_data};
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // Transfer sequencer. Each phase loads the counter with its length minus one
  // and moves on once the counter reaches zero. RS/DATA are only changed when
  // a new byte is launched from IDLE, so they stay put between transfers.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    pop          = 1'b0;
    lcd_rs_nxt   = lcd_rs;
    lcd_data_nxt = lcd_data;
`ifdef LCD_INIT_EN
    init_idx_nxt = init_idx;
`endif
    case (state)
      ST_IDLE: begin
`ifdef LCD_INIT_EN
        if (init_pending) begin
          lcd_rs_nxt   = 1'b0;
          lcd_data_nxt = init_cmd;
          init_idx_nxt = init_idx + 1'b1;
          state_nxt    = ST_SETUP;
          cnt_nxt      = LD_SETUP;
        end else
`endif
        if (!empty) begin
          pop                        = 1'b1;
          {lcd_rs_nxt, lcd_data_nxt} = fifo_mem[rd_ptr];
          state_nxt                  = ST_SETUP;
          cnt_nxt                    = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt == '0) begin
          state_nxt = ST_PULSE;
          cnt_nxt   = LD_PULSE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_PULSE: begin
        if (cnt == '0) begin
          state_nxt = ST_HOLD;
          cnt_nxt   = LD_HOLD;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_nxt = ST_EXEC;
          cnt_nxt   = is_long_cmd ? LD_CLEAR : LD_EXEC;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      ST_EXEC, ST_INIT: begin
        if (cnt == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Busy is registered from next-state values so it drops exactly on the edge
  // that enters IDLE with nothing left to send, and is 0 during reset.
  always_comb begin
    busy_nxt = (count_nxt != '0) || (state_nxt != ST_IDLE);
`ifdef LCD_INIT_EN
    if (init_idx_nxt < 3'd4) busy_nxt = 1'b1;
`endif
  end

  // EN is registered from the next state so the strobe is glitch-free and
  // drops asynchronously with reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
`ifdef LCD_INIT_EN
      state    <= ST_INIT;
      cnt      <= LD_INIT;
      init_idx <= '0;
`else
      state    <= ST_IDLE;
      cnt      <= '0;
`endif
      lcd_rs   <= 1'b0;
      lcd_data <= '0;
      lcd_en   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
`ifdef LCD_INIT_EN
      init_idx <= init_idx_nxt;
`endif
      lcd_rs   <= lcd_rs_nxt;
      lcd_data <= lcd_data_nxt;
      lcd_en   <= (state_nxt == ST_PULSE);
      busy     <= busy_nxt;
    end
  end

  // Power/backlight request is simply retimed, independent of transfers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lcd_on <= 1'b0;
    end else begin
      lcd_on <= i_lcd_on;
    end
  end

  assign o_wr_rdy   = !full;
  assign o_busy     = busy;
  assign o_lcd_data = lcd_data;
  assign o_lcd_rs   = lcd_rs;
  assign o_lcd_rw   = 1'b0;
  assign o_lcd_en   = lcd_en;
  assign o_lcd_on   = lcd_on;
  assign o_io_lcd   = {lcd_on, 20'b0, lcd_en, lcd_rs, 1'b0, lcd_data};

endmodule

// File: tb/tb_lcd_driver.sv
// ---------------------------------------------------------------------------
// tb_lcd_driver
//
// Self-checking bench for lcd_driver with short timing parameters.
// A reference model tracks the accepted bytes in a queue and, for the byte
// currently on the pins, the edge on which it was launched. All pin values
// are derived from the elapsed edges since that launch.
// ---------------------------------------------------------------------------
module tb_lcd_driver;

  localparam int TS    = 1;
  localparam int TP    = 2;
  localparam int TH    = 1;
  localparam int TE    = 4;
  localparam int TC    = 8;
  localparam int DEPTH = 4;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_wr_vld;
  logic        i_wr_rs;
  logic [7:0]  i_wr_data;
  logic        o_wr_rdy;
  logic        i_lcd_on;
  logic        o_busy;
  logic [7:0]  o_lcd_data;
  logic        o_lcd_rs;
  logic        o_lcd_rw;
  logic        o_lcd_en;
  logic        o_lcd_on;
  logic [31:0] o_io_lcd;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 0;

  lcd_driver #(
    .T_SETUP    (TS),
    .T_PULSE    (TP),
    .T_HOLD     (TH),
    .T_EXEC     (TE),
    .T_CLEAR    (TC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_wr_vld   (i_wr_vld),
    .i_wr_rs    (i_wr_rs),
    .i_wr_data  (i_wr_data),
    .o_wr_rdy   (o_wr_rdy),
    .i_lcd_on   (i_lcd_on),
    .o_busy     (o_busy),
    .o_lcd_data (o_lcd_data),
    .o_lcd_rs   (o_lcd_rs),
    .o_lcd_rw   (o_lcd_rw),
    .o_lcd_en   (o_lcd_en),
    .o_lcd_on   (o_lcd_on),
    .o_io_lcd   (o_io_lcd)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [8:0]  m_q[$];
  int          m_edge;
  bit          m_busy_xfer;
  int          m_launch;
  int          m_wait;
  logic        m_rs;
  logic [7:0]  m_data;
  logic        m_on;

  // One step per rising edge: launch the head byte if the previous transfer
  // has finished, then queue the incoming byte if there was room before it.
  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_q.delete();
      m_edge      = 0;
      m_busy_xfer = 0;
      m_launch    = 0;
      m_wait      = 0;
      m_rs        = 1'b0;
      m_data      = 8'h00;
      m_on        = 1'b0;
    end else begin
      bit       room;
      bit       idle;
      logic [8:0] item;
      m_edge++;
      room = (m_q.size() < DEPTH);
      idle = !m_busy_xfer || (m_edge > m_launch + TS + TP + TH + m_wait);
      if (idle && m_q.size() > 0) begin
        item        = m_q.pop_front();
        m_rs        = item[8];
        m_data      = item[7:0];
        m_busy_xfer = 1;
        m_launch    = m_edge;
        m_wait      = (!m_rs && m_data >= 8'h01 && m_data <= 8'h03) ? TC : TE;
      end
      if (i_wr_vld && room) m_q.push_back({i_wr_rs, i_wr_data});
      m_on = i_lcd_on;
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge i_clk) begin
    if (chk_en && i_rst_n) begin
      logic        e_en;
      logic        e_busy;
      logic [31:0] e_io;
      e_en   = m_busy_xfer && (m_edge >= m_launch + TS) && (m_edge < m_launch + TS + TP);
      e_busy = (m_q.size() > 0) ||
               (m_busy_xfer && (m_edge < m_launch + TS + TP + TH + m_wait));
      e_io   = {m_on, 20'b0, e_en, m_rs, 1'b0, m_data};
      checkOutput("model_io_lcd", o_io_lcd, e_io);
      checkOutput("model_en", {31'b0, o_lcd_en}, {31'b0, e_en});
      checkOutput("model_busy", {31'b0, o_busy}, {31'b0, e_busy});
      checkOutput("model_wr_rdy", {31'b0, o_wr_rdy}, {31'b0, (m_q.size() < DEPTH)});
      checkOutput("model_pins", {20'b0, o_lcd_on, o_lcd_rs, o_lcd_rw, 1'b0, o_lcd_data},
                  {20'b0, m_on, m_rs, 1'b0, 1'b0, m_data});
    end
  end

  // Strobe log: every rising EN records the byte on the bus.
  int         strobe_cnt = 0;
  logic [8:0] strobe_log[$];

  always @(posedge o_lcd_en) begin
    strobe_cnt++;
    strobe_log.push_back({o_lcd_rs, o_lcd_data});
  end

  // Drive one write and hold it until accepted. Called at a falling edge;
  // returns at the falling edge just after the accepting rising edge.
  task automatic applyStimulus(input logic rs, input logic [7:0] data);
    bit acc;
    acc       = 0;
    i_wr_vld  = 1'b1;
    i_wr_rs   = rs;
    i_wr_data = data;
    for (int k = 0; k < 200 && !acc; k++) begin
      acc = o_wr_rdy;
      @(negedge i_clk);
    end
    i_wr_vld = 1'b0;
    if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
  endtask

  // Send a single byte and report the edge (counted from acceptance) at which
  // busy dropped, plus the pin mirror seen after edge 2.
  task automatic runByte(input logic rs, input logic [7:0] data,
                         output int fall_edge, output logic [31:0] io_at2);
    fall_edge = 0;
    io_at2    = 32'h0;
    applyStimulus(rs, data);
    for (int n = 1; n <= 40 && fall_edge == 0; n++) begin
      @(negedge i_clk);
      if (n == 2) io_at2 = o_io_lcd;
      if (!o_busy) fall_edge = n;
    end
  endtask

  initial begin
    int          fall;
    logic [31:0] io2;
    int          s0;
    bit          found;
    logic [8:0]  sent[6];

    i_rst_n   = 1'b0;
    i_wr_vld  = 1'b0;
    i_wr_rs   = 1'b0;
    i_wr_data = 8'h00;
    i_lcd_on  = 1'b0;

    // Reset values while reset is held.
    @(negedge i_clk);
    checkOutput("rst_io_lcd", o_io_lcd, 32'h0);
    checkOutput("rst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("rst_wr_rdy", {31'b0, o_wr_rdy}, 32'd1);
    checkOutput("rst_pins", {o_lcd_data, o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on}, 12'h0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    chk_en  = 1;
    @(negedge i_clk);
    checkOutput("post_rst_io_lcd", o_io_lcd, 32'h0);

    // Single data byte.
    runByte(1'b1, 8'h41, fall, io2);
    checkOutput("single_io_at_en", io2, 32'h0000_0641);
    checkOutput("single_busy_fall", fall, 32'd9);

    // Clear takes the long wait, a normal command the short one.
    runByte(1'b0, 8'h01, fall, io2);
    checkOutput("clear_busy_fall", fall, 32'd13);
    runByte(1'b0, 8'h38, fall, io2);
    checkOutput("cmd38_busy_fall", fall, 32'd9);
    runByte(1'b0, 8'h03, fall, io2);
    checkOutput("home_busy_fall", fall, 32'd13);

    // FIFO full: six writes held back-to-back.
    sent[0] = 9'h1A0; sent[1] = 9'h1A1; sent[2] = 9'h0A2;
    sent[3] = 9'h1A3; sent[4] = 9'h1A4; sent[5] = 9'h1A5;
    strobe_log.delete();
    s0 = strobe_cnt;
    for (int i = 0; i < 6; i++) applyStimulus(sent[i][8], sent[i][7:0]);
    repeat (70) @(negedge i_clk);
    checkOutput("fifo_strobe_count", strobe_cnt - s0, 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < strobe_log.size()) checkOutput("fifo_order", {23'b0, strobe_log[i]}, {23'b0, sent[i]});
      else                       checkOutput("fifo_order_missing", 32'd0, 32'd1);
    end

    // Power request toggle.
    i_lcd_on = 1'b1;
    @(negedge i_clk);
    checkOutput("lcd_on_rise", {31'b0, o_lcd_on}, 32'd1);
    checkOutput("io_bit31_rise", {31'b0, o_io_lcd[31]}, 32'd1);
    i_lcd_on = 1'b0;
    @(negedge i_clk);
    checkOutput("lcd_on_fall", {31'b0, o_lcd_on}, 32'd0);
    checkOutput("io_bit31_fall", {31'b0, o_io_lcd[31]}, 32'd0);

    // Reset during the enable pulse with more bytes queued.
    applyStimulus(1'b1, 8'h10);
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h12);
    found = 0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (o_lcd_en) found = 1;
      else          @(negedge i_clk);
    end
    checkOutput("en_seen_before_reset", {31'b0, found}, 32'd1);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midrst_en", {31'b0, o_lcd_en}, 32'd0);
    checkOutput("midrst_io_lcd", o_io_lcd, 32'h0);
    checkOutput("midrst_busy", {31'b0, o_busy}, 32'd0);
    checkOutput("midrst_wr_rdy", {31'b0, o_wr_rdy}, 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    s0 = strobe_cnt;
    repeat (40) @(negedge i_clk);
    checkOutput("no_strobe_after_reset", strobe_cnt - s0, 32'd0);

    // Randomized traffic, including clear/home commands and power toggles.
    for (int c = 0; c < 400; c++) begin
      i_wr_vld = ($urandom_range(0, 2) == 0);
      i_wr_rs  = $urandom_range(0, 1);
      if ($urandom_range(0, 3) == 0) i_wr_data = 8'($urandom_range(1, 3));
      else                           i_wr_data = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) i_lcd_on = ~i_lcd_on;
      @(negedge i_clk);
    end
    i_wr_vld = 1'b0;
    repeat (100) @(negedge i_clk);
    checkOutput("drained_busy", {31'b0, o_busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
